// File: rtl/dtc_score_pkg.sv
// dtc_score_pkg: shared types and constants for the prediction-scoring window.
//   WIN_W_DEF : default width of window length and of every count
//   state_e   : window FSM states (IDLE, COLLECT, REPORT)
package dtc_score_pkg;
    localparam int WIN_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, COLLECT, REPORT} state_e;
endpackage

// File: rtl/dtc_score_if.sv
// dtc_score_if: bundle between a scoring consumer/producer (master) and dtc_score_window (slave).
//   start/win_len          : open a window of win_len predictions (0 treated as 1)
//   pred_valid/pred_ready  : prediction handshake carrying pred and label
//   res_valid/res_ready    : window summary handshake
//   ones/err/tp/fp/fn/tn   : live and final window counts
interface dtc_score_if import dtc_score_pkg::*; #(parameter int WIN_W = WIN_W_DEF);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             pred_valid;
    logic             pred_ready;
    logic             pred;
    logic             label;
    logic             res_valid;
    logic             res_ready;
    logic [WIN_W-1:0] ones_cnt;
    logic [WIN_W-1:0] err_cnt;
    logic [WIN_W-1:0] tp_cnt;
    logic [WIN_W-1:0] fp_cnt;
    logic [WIN_W-1:0] fn_cnt;
    logic [WIN_W-1:0] tn_cnt;
    modport master (
        output start, win_len, pred_valid, pred, label, res_ready,
        input  pred_ready, res_valid, ones_cnt, err_cnt, tp_cnt, fp_cnt, fn_cnt, tn_cnt
    );
    modport slave (
        input  start, win_len, pred_valid, pred, label, res_ready,
        output pred_ready, res_valid, ones_cnt, err_cnt, tp_cnt, fp_cnt, fn_cnt, tn_cnt
    );
endinterface

// File: rtl/dtc_score_cnt.sv
// dtc_score_cnt: W-bit event counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero the count (wins over inc)
//   inc        : add one
//   cnt        : current count
module dtc_score_cnt #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : cnt_q + W'(inc);
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/dtc_score_window.sv
// dtc_score_window: scores a window of classifier predictions against labels.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dtc_score_if slave (start/win_len, prediction handshake,
//                result handshake, ones/err and confusion-matrix counts)
// Build option: define DTC_SCORE_CONFMAT_EN to implement tp/fp/fn/tn counters;
// otherwise those ports are tied to zero.
module dtc_score_window import dtc_score_pkg::*; #(parameter int WIN_W = WIN_W_DEF) (
    input  logic     clk,
    input  logic     rst_n,
    dtc_score_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIN_W-1:0] rem_q, rem_d;
    logic             accept, clr;
    assign accept         = (state_q == COLLECT) && bus.pred_valid;
    assign clr            = (state_q == IDLE) && bus.start;
    assign bus.pred_ready = (state_q == COLLECT);
    assign bus.res_valid  = (state_q == REPORT);
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (clr) begin
            state_d = COLLECT;
            // a zero-length request still scores one sample
            rem_d   = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
        end else if (accept) begin
            rem_d   = rem_q - WIN_W'(1);
            state_d = (rem_q == WIN_W'(1)) ? REPORT : COLLECT;
        end else if (bus.res_valid && bus.res_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end
    dtc_score_cnt #(.W(WIN_W)) u_ones (.clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(accept && bus.pred), .cnt(bus.ones_cnt));
    dtc_score_cnt #(.W(WIN_W)) u_err (.clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(accept && (bus.pred ^ bus.label)), .cnt(bus.err_cnt));
`ifdef DTC_SCORE_CONFMAT_EN
    dtc_score_cnt #(.W(WIN_W)) u_tp (.clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(accept && bus.pred && bus.label), .cnt(bus.tp_cnt));
    dtc_score_cnt #(.W(WIN_W)) u_fp (.clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(accept && bus.pred && !bus.label), .cnt(bus.fp_cnt));
    dtc_score_cnt #(.W(WIN_W)) u_fn (.clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(accept && !bus.pred && bus.label), .cnt(bus.fn_cnt));
    dtc_score_cnt #(.W(WIN_W)) u_tn (.clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(accept && !bus.pred && !bus.label), .cnt(bus.tn_cnt));
`else
    assign bus.tp_cnt = '0;
    assign bus.fp_cnt = '0;
    assign bus.fn_cnt = '0;
    assign bus.tn_cnt = '0;
`endif
endmodule
